load_store_unit: RTL and testbench

- Multi-cycle memory-access stage directly downstream of the ALU.
- Takes the effective address the ALU computes for load/store instructions (op1 + immediate) and the store operand, then runs one data-memory transaction over a req/ready handshake.
- Loads return byte/half/word data, sign- or zero-extended to 32 bits, for register writeback.
- Stores produce lane-replicated write data and a byte-enable mask.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 127 ++++++++++++
 tb/tb_load_store_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store types: FSM states, func3 access encodings and major opcodes.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] LTYPE = 7'b0000011;
  localparam logic [6:0] STYPE = 7'b0100011;

endpackage

// File: rtl/lsu_align.sv
// Combinational store lane replication/byte mask, load extraction/extension and access legality.
// Zero latency; no handshake.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic        check_align,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic [31:0] load_val,
  output logic        bad
);

  logic [31:0] byte_lane;
  logic [31:0] half_lane;
  logic        legal;
  logic        misaligned;

  assign byte_lane = rdata >> {addr_lo, 3'b000};
  assign half_lane = rdata >> {addr_lo[1], 4'b0000};

  always_comb begin
    wdata    = '0;
    wmask    = '0;
    load_val = '0;
    case (func3)
      F3_B: begin
        wdata    = {4{store_data[7:0]}};
        wmask    = 4'b0001 << addr_lo;
        load_val = {{24{byte_lane[7]}}, byte_lane[7:0]};
      end
      F3_H: begin
        wdata    = {2{store_data[15:0]}};
        wmask    = 4'b0011 << {addr_lo[1], 1'b0};
        load_val = {{16{half_lane[15]}}, half_lane[15:0]};
      end
      F3_W: begin
        wdata    = store_data;
        wmask    = 4'b1111;
        load_val = rdata;
      end
      F3_BU:   load_val = {24'h0, byte_lane[7:0]};
      F3_HU:   load_val = {16'h0, half_lane[15:0]};
      default: ;
    endcase
  end

  // Unsigned encodings exist only for loads.
  assign legal = is_store ? (func3 == F3_B || func3 == F3_H || func3 == F3_W)
                          : (func3 == F3_B || func3 == F3_H || func3 == F3_W ||
                             func3 == F3_BU || func3 == F3_HU);

  assign misaligned = ((func3 == F3_H || func3 == F3_HU) && addr_lo[0]) ||
                      ((func3 == F3_W) && (addr_lo != 2'b00));

  assign bad = !legal || (check_align && misaligned);

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ready data-memory transaction per start, 3+ cycles start-to-idle.
// mem_req holds until mem_ready; start is ignored while busy. LSU_MISALIGN_TRAP_EN enables alignment traps.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MASK_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        func3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [XLEN-1:0]   load_data
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_MISALIGN = 1'b1;
`else
  localparam logic TRAP_MISALIGN = 1'b0;
`endif

  lsu_state_t  state;
  logic        is_store_q;
  logic [2:0]  func3_q;
  logic [1:0]  addr_lo_q;

  logic        sel_store;
  logic [2:0]  sel_func3;
  logic [1:0]  sel_addr_lo;
  logic [31:0] al_wdata;
  logic [3:0]  al_wmask;
  logic [31:0] al_load;
  logic        al_bad;

  // In IDLE the aligner looks at the incoming request; afterwards at the latched one.
  assign sel_store   = (state == IDLE) ? is_store   : is_store_q;
  assign sel_func3   = (state == IDLE) ? func3      : func3_q;
  assign sel_addr_lo = (state == IDLE) ? addr[1:0]  : addr_lo_q;

  lsu_align u_align (
    .is_store    (sel_store),
    .func3       (sel_func3),
    .addr_lo     (sel_addr_lo),
    .check_align (TRAP_MISALIGN),
    .store_data  (store_data),
    .rdata       (mem_rdata),
    .wdata       (al_wdata),
    .wmask       (al_wmask),
    .load_val    (al_load),
    .bad         (al_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      func3_q    <= '0;
      addr_lo_q  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      load_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_store_q <= is_store;
            func3_q    <= func3;
            addr_lo_q  <= addr[1:0];
            busy       <= 1'b1;
            if (al_bad) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= ACCESS;
              err       <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[XLEN-1:2], 2'b00};
              mem_wdata <= is_store ? al_wdata : '0;
              mem_wmask <= is_store ? al_wmask : '0;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state     <= DONE;
            done      <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= '0;
            if (!is_store_q) load_data <= al_load;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plan steps plus randomized accesses checked against a byte-lane model of the LSU.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] load_data;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic [31:0] exp_ld = '0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .func3      (func3),
    .addr       (addr),
    .store_data (store_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .load_data  (load_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes decides legality, lanes and extension.
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rd,
                                output logic bad, output logic [31:0] ew,
                                output logic [3:0] em, output logic [31:0] el);
    int size = 0;
    bit sgn  = 0;
    int off  = 0;
    logic [31:0] raw;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = st ? 0 : 1;
      3'd5: size = st ? 0 : 2;
      default: size = 0;
    endcase
    bad = (size == 0);
`ifdef LSU_MISALIGN_TRAP_EN
    if (size > 0 && (a % size) != 0) bad = 1'b1;
`endif
    ew = '0;
    em = '0;
    el = '0;
    if (size > 0) begin
      off = ((a % 4) / size) * size;
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + size) em[i] = 1'b1;
        ew[8*i +: 8] = sd[8*(i % size) +: 8];
      end
      raw = rd >> (8 * off);
      if (size < 4) begin
        raw = raw & ((32'd1 << (8 * size)) - 32'd1);
        if (sgn && raw[8*size-1]) raw = raw - (32'd1 << (8 * size));
      end
      el = raw;
    end
  endfunction

  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] rd,
                            input int wt, input bit poke);
    logic bad;
    logic [31:0] ew;
    logic [31:0] el;
    logic [3:0] em;
    logic seen_req;
    int n;
    model(st, f3, a, sd, rd, bad, ew, em, el);
    @(negedge clk);
    start = 1'b1; is_store = st; func3 = f3; addr = a; store_data = sd; mem_rdata = rd;
    @(negedge clk);
    start = poke; is_store = ~st; func3 = 3'(f3 + 3'd1); addr = $urandom;
    check("busy_after_start", 32'(busy), 32'd1);
    if (bad) begin
      seen_req = mem_req;
      n = 0;
      while (!done && n < 4) begin
        @(negedge clk);
        seen_req |= mem_req;
        n++;
      end
      check("err_done", 32'(done), 32'd1);
      check("err_flag", 32'(err), 32'd1);
      check("err_no_req", 32'(seen_req), 32'd0);
      check("err_load_kept", load_data, exp_ld);
    end else begin
      for (int w = 0; w <= wt; w++) begin
        if (w > 0) @(negedge clk);
        check("req", 32'(mem_req), 32'd1);
        check("done_early", 32'(done), 32'd0);
        check("we", 32'(mem_we), 32'(st));
        check("maddr", mem_addr, {a[31:2], 2'b00});
        check("wmask", 32'(mem_wmask), st ? 32'(em) : 32'd0);
        if (st) check("wdata", mem_wdata, ew);
        mem_ready = (w == wt);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      if (!st) exp_ld = el;
      check("done", 32'(done), 32'd1);
      check("err_clear", 32'(err), 32'd0);
      check("req_dropped", 32'(mem_req), 32'd0);
      check("load_data", load_data, exp_ld);
    end
    @(negedge clk);
    start = 1'b0;
    check("done_single", 32'(done), 32'd0);
    check("idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; is_store = 1'b0; func3 = '0; addr = '0;
    store_data = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mask", 32'(mem_wmask), 32'd0);
    check("rst_ld", load_data, 32'd0);
    rst = 1'b0;

    run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    check("lw_const", load_data, 32'hDEADBEEF);
    run_access(1'b0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0, 1'b0);
    check("lb_const", load_data, 32'hFFFFFF80);
    run_access(1'b0, 3'b100, 32'h203, 32'h0, 32'h80112233, 1, 1'b0);
    check("lbu_const", load_data, 32'h00000080);
    run_access(1'b1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0, 3, 1'b0);
    run_access(1'b1, 3'b010, 32'h401, 32'h12345678, 32'h0, 0, 1'b0);
    run_access(1'b0, 3'b011, 32'h500, 32'h0, 32'h0, 0, 1'b1);
    run_access(1'b0, 3'b101, 32'h602, 32'h0, 32'h8001C0DE, 2, 1'b1);

    // Reset during a stalled access aborts it without a done pulse.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; func3 = 3'b010; addr = 32'h700;
    @(negedge clk);
    start = 1'b0;
    check("abort_req_up", 32'(mem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_req_drop", 32'(mem_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_ld = '0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", 32'(cnt), 32'd0);
    run_access(1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      run_access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
